rv_encode_loader: RTL and testbench

//  Inverse of the core's instruction decode: accepts field-level instruction requests (type, regs, funct, imm),

---
 rtl/rv_encode_loader_pkg.sv | 34 +++
 rtl/rv_encode_loader_encode.sv | 38 +++
 rtl/rv_encode_loader.sv | 101 ++++++++++
 tb/tb_rv_encode_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_encode_loader_pkg.sv
// Shared types and constants for the RV32I instruction encode loader.
// Instruction format codes, loader FSM states, opcode constants, helpers.
package rv_pkg;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } instr_type_e;

    typedef logic [1:0] loader_state_e;

    localparam loader_state_e ST_IDLE = 2'd0;
    localparam loader_state_e ST_LOAD = 2'd1;
    localparam loader_state_e ST_DONE = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    function automatic logic is_legal_type(input logic [2:0] t);
        return (t <= 3'd5);
    endfunction

endpackage

// File: rtl/rv_encode_loader_encode.sv
// rv_encode: combinational field-bundle to RV32I word packer.
// Ports: instr_type/op/rd/rs1/rs2/funct3/funct7/imm in; word, legal out.
import rv_pkg::*;

module rv_encode (
    input  logic [2:0]  instr_type,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [19:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [24:0] hi;

    always_comb begin
        hi    = '0;
        legal = is_legal_type(instr_type);
        case (instr_type)
            TYPE_R: hi = {funct7, rs2, rs1, funct3, rd};
            TYPE_I: hi = {imm[11:0], rs1, funct3, rd};
            TYPE_S: hi = {imm[11:5], rs2, rs1, funct3, imm[4:0]};
            // imm arrives in decode order: bit 11 -> word[31], bit 10 -> word[7]
            TYPE_B: hi = {imm[11], imm[9:4], rs2, rs1, funct3,
                          imm[3:0], imm[10]};
            TYPE_U: hi = {imm[19:0], rd};
            // J imm is already permuted {31,19:12,20,30:21} by the producer
            TYPE_J: hi = {imm[19:0], rd};
            default: hi = '0;
        endcase
        word = {hi, op};
    end

endmodule

// File: rtl/rv_encode_loader.sv
// Streams packed RV32I words into imem through a sequential write port.
// Ports: start/req handshake+fields in; imem we/addr/data, count, done, err out.
import rv_pkg::*;

module rv_encode_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_last_i,
    input  logic [2:0]               req_type_i,
    input  logic [6:0]               req_op_i,
    input  logic [4:0]               req_rd_i,
    input  logic [4:0]               req_rs1_i,
    input  logic [4:0]               req_rs2_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [6:0]               req_funct7_i,
    input  logic [19:0]              req_imm_i,
    output logic                     imem_we_o,
    output logic [31:0]              imem_addr_o,
    output logic [31:0]              imem_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    loader_state_e state;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          wr;
    logic          hit;
    logic [CW-1:0] count_next;

    rv_encode u_encode (
        .instr_type (req_type_i),
        .op         (req_op_i),
        .rd         (req_rd_i),
        .rs1        (req_rs1_i),
        .rs2        (req_rs2_i),
        .funct3     (req_funct3_i),
        .funct7     (req_funct7_i),
        .imm        (req_imm_i),
        .word       (enc_word),
        .legal      (enc_legal)
    );

    assign req_ready_o = (state == ST_LOAD);
    assign accept      = req_valid_i & req_ready_o;
    assign wr          = accept & enc_legal;
    assign count_next  = count_o + 1'b1;
    assign hit         = wr && (count_next == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            imem_we_o   <= 1'b0;
            imem_addr_o <= BASE_ADDR;
            imem_data_o <= '0;
            count_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // address moves on once the write it carried has been driven
            if (imem_we_o)
                imem_addr_o <= imem_addr_o + 32'd4;
            imem_we_o <= wr;
            if (wr) begin
                imem_data_o <= enc_word;
                count_o     <= count_next;
            end
            if (accept && !enc_legal)
                err_o <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (accept && (req_last_i || hit)) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state       <= ST_LOAD;
                        imem_addr_o <= BASE_ADDR;
                        count_o     <= '0;
                        done_o      <= 1'b0;
                        err_o       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_encode_loader.sv
// Self-checking bench for rv_encode_loader: directed encodings, random
// round trip through a behavioural decoder, depth cap, illegal type, resets.
module tb_rv_encode_loader;

    localparam logic [31:0] A_BASE = 32'h0000_1000;
    localparam logic [31:0] B_BASE = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        valid;
    logic        last;
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [19:0] imm;

    logic        a_ready, a_we, a_done, a_err;
    logic [31:0] a_addr, a_data;
    logic [10:0] a_count;
    logic        b_ready, b_we, b_done, b_err;
    logic [31:0] b_addr, b_data;
    logic [2:0]  b_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [19:0] imm;
    } fld_t;

    typedef struct {
        logic [2:0] t;
        fld_t       f;
    } req_t;

    always #5 clk = ~clk;

    rv_encode_loader #(.BASE_ADDR(A_BASE), .DEPTH(1024)) dut_a (
        .clk(clk), .reset(reset), .start_i(start),
        .req_valid_i(valid), .req_ready_o(a_ready), .req_last_i(last),
        .req_type_i(typ), .req_op_i(op), .req_rd_i(rd),
        .req_rs1_i(rs1), .req_rs2_i(rs2), .req_funct3_i(f3),
        .req_funct7_i(f7), .req_imm_i(imm),
        .imem_we_o(a_we), .imem_addr_o(a_addr), .imem_data_o(a_data),
        .count_o(a_count), .done_o(a_done), .err_o(a_err)
    );

    rv_encode_loader #(.BASE_ADDR(B_BASE), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start_i(start),
        .req_valid_i(valid), .req_ready_o(b_ready), .req_last_i(last),
        .req_type_i(typ), .req_op_i(op), .req_rd_i(rd),
        .req_rs1_i(rs1), .req_rs2_i(rs2), .req_funct3_i(f3),
        .req_funct7_i(f7), .req_imm_i(imm),
        .imem_we_o(b_we), .imem_addr_o(b_addr), .imem_data_o(b_data),
        .count_o(b_count), .done_o(b_done), .err_o(b_err)
    );

    // fields meaningful for a given format; everything else zeroed
    function automatic fld_t norm(input logic [2:0] t, input fld_t r);
        fld_t n = '0;
        n.op = r.op;
        case (t)
            3'd0: begin n.rd = r.rd; n.rs1 = r.rs1; n.rs2 = r.rs2;
                        n.f3 = r.f3; n.f7 = r.f7; end
            3'd1: begin n.rd = r.rd; n.rs1 = r.rs1; n.f3 = r.f3;
                        n.imm = {8'b0, r.imm[11:0]}; end
            3'd2, 3'd3: begin n.rs1 = r.rs1; n.rs2 = r.rs2; n.f3 = r.f3;
                        n.imm = {8'b0, r.imm[11:0]}; end
            default: begin n.rd = r.rd; n.imm = r.imm; end
        endcase
        return n;
    endfunction

    // behavioural RV32I decoder producing the same immediate packing
    function automatic fld_t decode(input logic [2:0] t, input logic [31:0] w);
        fld_t d = '0;
        d.op = w[6:0];
        case (t)
            3'd0: begin d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
                        d.rs2 = w[24:20]; d.f7 = w[31:25]; end
            3'd1: begin d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
                        d.imm = {8'b0, w[31:20]}; end
            3'd2: begin d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                        d.imm = {8'b0, w[31:25], w[11:7]}; end
            3'd3: begin d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                        d.imm = {8'b0, w[31], w[7], w[30:25], w[11:8]}; end
            default: begin d.rd = w[11:7]; d.imm = w[31:12]; end
        endcase
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input fld_t f, input logic l);
        valid = 1'b1; last = l; typ = t;
        op = f.op; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
        f3 = f.f3; f7 = f.f7; imm = f.imm;
    endtask

    task automatic idle_in();
        valid = 1'b0; last = 1'b0; start = 1'b0;
    endtask

    function automatic fld_t rand_fld();
        fld_t f;
        f.op = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom); f.f3 = 3'($urandom); f.f7 = 7'($urandom);
        f.imm = 20'($urandom);
        return f;
    endfunction

    task automatic restart();
        idle_in();
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        idle_in(); typ = '0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        f3 = '0; f7 = '0; imm = '0;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_we !== 1'b0 || a_addr !== A_BASE ||
            a_data !== 32'h0 || a_count !== 11'd0 || a_done !== 1'b0 ||
            a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_a rdy=%b we=%b addr=%h data=%h cnt=%0d done=%b err=%b want 0/0/%h/0/0/0/0",
                     a_ready, a_we, a_addr, a_data, a_count, a_done, a_err, A_BASE);
        end
        checks++;
        if (b_ready !== 1'b0 || b_we !== 1'b0 || b_addr !== B_BASE ||
            b_count !== 3'd0 || b_done !== 1'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_b rdy=%b we=%b addr=%h cnt=%0d done=%b err=%b",
                     b_ready, b_we, b_addr, b_count, b_done, b_err);
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got %b want 1", a_ready);
        end
    endtask

    task automatic test_known();
        fld_t f;
        restart();
        f = '0; f.op = 7'h33; f.rd = 5'd3; f.rs1 = 5'd1; f.rs2 = 5'd2;
        drive(3'd0, f, 1'b0); tick();
        checks++;
        if (a_we !== 1'b1 || a_addr !== A_BASE || a_data !== 32'h002081B3) begin
            errors++;
            $display("FAIL add we=%b addr=%h data=%h want 1 %h 002081b3",
                     a_we, a_addr, a_data, A_BASE);
        end
        f = '0; f.op = 7'h13; f.rd = 5'd5; f.imm = 20'hFFFFF;
        drive(3'd1, f, 1'b0); tick();
        checks++;
        if (a_we !== 1'b1 || a_addr !== A_BASE + 32'd4 ||
            a_data !== 32'hFFF00293) begin
            errors++;
            $display("FAIL addi we=%b addr=%h data=%h want fff00293",
                     a_we, a_addr, a_data);
        end
        f = '0; f.op = 7'h63; f.imm = 20'h00800;
        drive(3'd3, f, 1'b1); tick();
        checks++;
        if (a_we !== 1'b1 || a_data !== 32'h80000063 || a_done !== 1'b1 ||
            a_count !== 11'd3) begin
            errors++;
            $display("FAIL beq we=%b data=%h done=%b cnt=%0d want 80000063 1 3",
                     a_we, a_data, a_done, a_count);
        end
        idle_in(); tick();
        checks++;
        if (a_we !== 1'b0 || a_ready !== 1'b0 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL after_last we=%b rdy=%b done=%b want 0 0 1",
                     a_we, a_ready, a_done);
        end
    endtask

    task automatic test_roundtrip();
        req_t q[$];
        req_t r, e;
        fld_t d, n;
        int sent = 0;
        int wrote = 0;
        int bad = 0;
        bit acc;
        restart();
        for (int cyc = 0; cyc < 3000 && wrote < 1000; cyc++) begin
            valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            r.t = 3'($urandom_range(0, 5));
            r.f = rand_fld();
            drive(r.t, r.f, sent == 999);
            valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            acc = valid && a_ready;
            if (acc) begin q.push_back(r); sent++; end
            tick();
            checks++;
            if (a_we !== acc) begin
                errors++;
                $display("FAIL rt_we cyc=%0d got %b want %b", cyc, a_we, acc);
            end
            if (a_we === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                d = decode(e.t, a_data);
                n = norm(e.t, e.f);
                checks++;
                if (d !== n || a_addr !== A_BASE + 32'(4 * wrote)) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL rt_word k=%0d t=%0d data=%h addr=%h dec=%h want %h",
                                 wrote, e.t, a_data, a_addr, d, n);
                end
                wrote++;
            end
        end
        idle_in(); tick();
        checks++;
        if (wrote != 1000 || a_done !== 1'b1 || a_count !== 11'd1000 ||
            a_ready !== 1'b0) begin
            errors++;
            $display("FAIL rt_end writes=%0d done=%b cnt=%0d rdy=%b want 1000 1 1000 0",
                     wrote, a_done, a_count, a_ready);
        end
    endtask

    task automatic test_back_to_back();
        fld_t f;
        int writes = 0;
        restart();
        for (int i = 0; i < 6; i++) begin
            f = rand_fld();
            drive(3'd0, f, 1'b0);
            checks++;
            if (b_ready !== (i < 4)) begin
                errors++;
                $display("FAIL b2b_ready i=%0d got %b want %b", i, b_ready, i < 4);
            end
            tick();
            if (b_we === 1'b1) writes++;
            checks++;
            if (b_we !== (i < 4) ||
                (i < 4 && b_addr !== B_BASE + 32'(4 * i))) begin
                errors++;
                $display("FAIL b2b_write i=%0d we=%b addr=%h", i, b_we, b_addr);
            end
        end
        idle_in();
        checks++;
        if (writes != 4 || b_done !== 1'b1 || b_count !== 3'd4 ||
            b_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end writes=%0d done=%b cnt=%0d rdy=%b want 4 1 4 0",
                     writes, b_done, b_count, b_ready);
        end
    endtask

    task automatic test_illegal();
        fld_t f;
        restart();
        f = rand_fld();
        drive(3'd0, f, 1'b0); tick();
        drive(3'd7, f, 1'b0); tick();
        checks++;
        if (a_we !== 1'b0 || a_err !== 1'b1 || a_count !== 11'd1) begin
            errors++;
            $display("FAIL illegal we=%b err=%b cnt=%0d want 0 1 1",
                     a_we, a_err, a_count);
        end
        drive(3'd1, f, 1'b1); tick();
        checks++;
        if (a_we !== 1'b1 || a_addr !== A_BASE + 32'd4 || a_err !== 1'b1 ||
            a_count !== 11'd2 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL illegal_next we=%b addr=%h err=%b cnt=%0d done=%b",
                     a_we, a_addr, a_err, a_count, a_done);
        end
        // start while the last write is on the port: new session follows
        idle_in(); start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (a_err !== 1'b0 || a_count !== 11'd0 || a_done !== 1'b0 ||
            a_ready !== 1'b1 || a_we !== 1'b0) begin
            errors++;
            $display("FAIL restart err=%b cnt=%0d done=%b rdy=%b we=%b",
                     a_err, a_count, a_done, a_ready, a_we);
        end
        drive(3'd6, f, 1'b1); tick();
        idle_in();
        checks++;
        if (a_we !== 1'b0 || a_err !== 1'b1 || a_done !== 1'b1 ||
            a_ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal_last we=%b err=%b done=%b rdy=%b want 0 1 1 0",
                     a_we, a_err, a_done, a_ready);
        end
    endtask

    task automatic test_start_in_load();
        fld_t f;
        restart();
        f = rand_fld();
        drive(3'd4, f, 1'b0); tick();
        idle_in(); start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (a_count !== 11'd1 || a_ready !== 1'b1 || a_addr !== A_BASE + 32'd4) begin
            errors++;
            $display("FAIL start_in_load cnt=%0d rdy=%b addr=%h want 1 1 %h",
                     a_count, a_ready, a_addr, A_BASE + 32'd4);
        end
    endtask

    task automatic test_reset_mid();
        fld_t f;
        restart();
        f = rand_fld();
        drive(3'd2, f, 1'b0); tick();
        drive(3'd5, f, 1'b0); reset = 1'b1; tick();
        reset = 1'b0; idle_in();
        checks++;
        if (a_we !== 1'b0 || a_ready !== 1'b0 || a_addr !== A_BASE ||
            a_data !== 32'h0 || a_count !== 11'd0 || a_done !== 1'b0 ||
            a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid we=%b rdy=%b addr=%h data=%h cnt=%0d done=%b err=%b",
                     a_we, a_ready, a_addr, a_data, a_count, a_done, a_err);
        end
        tick();
        checks++;
        if (a_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_we got %b want 0", a_we);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_known();
        test_roundtrip();
        test_back_to_back();
        test_illegal();
        test_start_in_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
